// File: rtl/sim_run_ctrl_if.sv
// Handshake bundle between the bench-side run controller user and sim_run_ctrl:
// run stimulus taps from the core plus the controller's status/report outputs.
interface sim_run_ctrl_if #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32,
   parameter int CNT_W   = 32
);
   logic               restart;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               core_rst;
   logic               running;
   logic               done;
   logic               timeout;
   logic [CNT_W-1:0]   cycle_count;
   logic [CNT_W-1:0]   instr_count;
   logic [PC_W-1:0]    halt_pc;

   modport master (
      output restart, pc, instr, instr_valid,
      input  core_rst, running, done, timeout, cycle_count, instr_count, halt_pc
   );

   modport slave (
      input  restart, pc, instr, instr_valid,
      output core_rst, running, done, timeout, cycle_count, instr_count, halt_pc
   );
endinterface

// File: rtl/sim_run_ctrl.sv
// Run controller for MIPS core simulation: stretched core reset, halt/stall
// completion detection, cycle budget with timeout, and run statistics.
module sim_run_ctrl #(
   parameter int                 PC_W         = 32,
   parameter int                 INSTR_W      = 32,
   parameter int                 CNT_W        = 32,
   parameter int                 RESET_CYCLES = 2,
   parameter int                 MAX_CYCLES   = 50,
   parameter logic [INSTR_W-1:0] HALT_INSTR   = 'h0000000C,
   parameter int                 STALL_LIMIT  = 8
) (
   input logic         clk,
   input logic         rst,
   sim_run_ctrl_if.slave bus
);

   typedef enum logic [1:0] {HOLD, RUN, HALTED, TIMEOUT} state_t;

   localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0]  BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0]  STALL_LAST  = CNT_W'((STALL_LIMIT == 0) ? 0 : STALL_LIMIT - 1);

   state_t             state;
   state_t             state_next;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [CNT_W-1:0]   cycle_cnt;
   logic [CNT_W-1:0]   instr_cnt;
   logic [CNT_W-1:0]   stall_cnt;
   logic [PC_W-1:0]    prev_pc;
   logic               prev_valid;
   logic [PC_W-1:0]    halt_pc_q;
   logic               done_q;
   logic               timeout_q;
   logic               pc_repeat;
   logic               halt_hit;
   logic               budget_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= HOLD;
      end else begin
         state <= state_next;
      end
   end

   // Halt beats the budget on the same edge, so a halt on the last budgeted
   // cycle still reports done rather than timeout.
   always_comb begin
      state_next = state;
      pc_repeat  = prev_valid && (bus.pc == prev_pc);
      halt_hit   = (bus.instr_valid && (bus.instr == HALT_INSTR)) ||
                   ((STALL_LIMIT != 0) && pc_repeat && (stall_cnt == STALL_LAST));
      budget_hit = (cycle_cnt == BUDGET_LAST);
      case (state)
         HOLD:    if (hold_cnt == HOLD_LAST) state_next = RUN;
         RUN: begin
            if (halt_hit)        state_next = HALTED;
            else if (budget_hit) state_next = TIMEOUT;
         end
         HALTED,
         TIMEOUT: if (bus.restart) state_next = HOLD;
         default: state_next = HOLD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt   <= '0;
         cycle_cnt  <= '0;
         instr_cnt  <= '0;
         stall_cnt  <= '0;
         prev_pc    <= '0;
         prev_valid <= 1'b0;
         halt_pc_q  <= '0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         case (state)
            HOLD: begin
               hold_cnt <= (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + 1'b1;
            end
            RUN: begin
               cycle_cnt  <= cycle_cnt + 1'b1;
               if (bus.instr_valid) instr_cnt <= instr_cnt + 1'b1;
               prev_pc    <= bus.pc;
               prev_valid <= 1'b1;
               stall_cnt  <= pc_repeat ? stall_cnt + 1'b1 : '0;
               if (halt_hit) begin
                  done_q    <= 1'b1;
                  halt_pc_q <= bus.pc;
               end else if (budget_hit) begin
                  timeout_q <= 1'b1;
                  halt_pc_q <= bus.pc;
               end
            end
            HALTED,
            TIMEOUT: begin
               // Re-arm: the next run must start as clean as after rst.
               if (bus.restart) begin
                  hold_cnt   <= '0;
                  cycle_cnt  <= '0;
                  instr_cnt  <= '0;
                  stall_cnt  <= '0;
                  prev_pc    <= '0;
                  prev_valid <= 1'b0;
                  halt_pc_q  <= '0;
                  done_q     <= 1'b0;
                  timeout_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.core_rst    = (state == HOLD);
   assign bus.running     = (state == RUN);
   assign bus.done        = done_q;
   assign bus.timeout     = timeout_q;
   assign bus.cycle_count = cycle_cnt;
   assign bus.instr_count = instr_cnt;
   assign bus.halt_pc     = halt_pc_q;

endmodule
